negate_arbiter: RTL and testbench

NEGATE_ARBITER -- requirements
Module: negate_arbiter

---
 rtl/negate_arbiter.sv | 135 +++++++++++++
 tb/tb_negate_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/negate_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : negate_arbiter
// Function : Two-requester round-robin arbiter feeding a nibble-serial 8-bit
//            two's-complement negator built around one shared 4-bit adder.
// Revision : 1.0
// ============================================================================
module negate_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    input  logic [7:0] A0,
    input  logic [7:0] A1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [7:0] Output,
    output logic       c_out,
    output logic       ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] op_q,    op_d;
    logic [1:0] gnt_q,   gnt_d;
    logic       done_q,  done_d;
    logic       id_q,    id_d;
    logic       rr_q,    rr_d;
    logic [7:0] out_q,   out_d;
    logic       cy_q,    cy_d;
    logic       cout_q,  cout_d;
    logic       ovf_q,   ovf_d;

    logic [3:0] add_a;
    logic       add_b;
    logic [4:0] add_sum;
    logic       pick;

    // Shared nibble adder: low nibble adds the +1, high nibble adds the carry.
    assign add_a   = (state_q == S_LOW) ? ~op_q[3:0] : ~op_q[7:4];
    assign add_b   = (state_q == S_LOW) ? 1'b1 : cy_q;
    assign add_sum = {1'b0, add_a} + {4'b0000, add_b};

    // rr_q holds the last completed requester; on contention the other wins.
    assign pick = (req == 2'b11) ? ~rr_q : req[1];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        id_d    = id_q;
        rr_d    = rr_q;
        out_d   = out_q;
        cy_d    = cy_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (en) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    gnt_d = 2'b00;
                    if (req != 2'b00) begin
                        id_d    = pick;
                        op_d    = pick ? A1 : A0;
                        gnt_d   = pick ? 2'b10 : 2'b01;
                        state_d = S_LOW;
                    end
                end
                S_LOW: begin
                    out_d[3:0] = add_sum[3:0];
                    cy_d       = add_sum[4];
                    state_d    = S_HIGH;
                end
                S_HIGH: begin
                    out_d[7:4] = add_sum[3:0];
                    cout_d     = add_sum[4];
                    ovf_d      = (op_q == 8'h80);
                    state_d    = S_DONE;
                end
                S_DONE: begin
                    // Grant stays up through the done pulse; IDLE drops it.
                    done_d  = 1'b1;
                    rr_d    = id_q;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 8'h00;
            gnt_q   <= 2'b00;
            done_q  <= 1'b0;
            id_q    <= 1'b0;
            rr_q    <= 1'b1;
            out_q   <= 8'h00;
            cy_q    <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            out_q   <= out_d;
            cy_q    <= cy_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign done_id = id_q;
    assign Output  = out_q;
    assign c_out   = cout_q;
    assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_negate_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_negate_arbiter
// Function : Directed self-checking bench for negate_arbiter.
// Revision : 1.0
// ============================================================================
module tb_negate_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] req;
    logic [7:0] A0;
    logic [7:0] A1;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic       done_id;
    logic [7:0] Output;
    logic       c_out;
    logic       ovf;

    int n_total = 0;
    int n_pass  = 0;

    negate_arbiter u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .A0      (A0),
        .A1      (A1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .Output  (Output),
        .c_out   (c_out),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant edge, then count cycles until done (bounded).
    task automatic run_op(output int lat);
        lat = 0;
        tick();
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check_val("done_seen", {15'd0, done}, 16'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_gnt"},  {14'd0, gnt},  16'd0);
        check_val({tag, "_busy"}, {15'd0, busy}, 16'd0);
        check_val({tag, "_done"}, {15'd0, done}, 16'd0);
        check_val({tag, "_id"},   {15'd0, done_id}, 16'd0);
        check_val({tag, "_out"},  {8'd0, Output}, 16'd0);
        check_val({tag, "_cout"}, {15'd0, c_out}, 16'd0);
        check_val({tag, "_ovf"},  {15'd0, ovf},  16'd0);
    endtask

    initial begin
        int lat;
        int dones;
        rst_n = 1'b0; en = 1'b1; req = 2'b00; A0 = 8'h00; A1 = 8'h00;
        tick(); tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Single requester 0, operand 05; req dropped after grant must not abort.
        req = 2'b01; A0 = 8'h05;
        tick();
        check_val("t1_gnt",  {14'd0, gnt},  16'h0001);
        check_val("t1_busy", {15'd0, busy}, 16'd1);
        req = 2'b00;
        tick();
        check_val("t1_low_out", {8'd0, Output}, 16'h000B);
        tick();
        check_val("t1_high_out", {8'd0, Output}, 16'h00FB);
        check_val("t1_nodone", {15'd0, done}, 16'd0);
        tick();
        check_val("t1_done",  {15'd0, done},    16'd1);
        check_val("t1_id",    {15'd0, done_id}, 16'd0);
        check_val("t1_out",   {8'd0, Output},   16'h00FB);
        check_val("t1_cout",  {15'd0, c_out},   16'd0);
        check_val("t1_ovf",   {15'd0, ovf},     16'd0);
        check_val("t1_gnt_d", {14'd0, gnt},     16'h0001);
        tick();
        check_val("t1_end_done", {15'd0, done}, 16'd0);
        check_val("t1_end_gnt",  {14'd0, gnt},  16'd0);

        // Requester 1, operand 00: carry out set.
        req = 2'b10; A1 = 8'h00;
        run_op(lat);
        check_val("t2_lat",  lat[15:0], 16'd3);
        check_val("t2_id",   {15'd0, done_id}, 16'd1);
        check_val("t2_out",  {8'd0, Output},   16'h0000);
        check_val("t2_cout", {15'd0, c_out},   16'd1);
        check_val("t2_ovf",  {15'd0, ovf},     16'd0);
        req = 2'b00;
        tick();

        // Round-robin under continuous contention, starting from reset.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req = 2'b11; A0 = 8'h01; A1 = 8'h80;
        run_op(lat);
        check_val("t3a_id",  {15'd0, done_id}, 16'd0);
        check_val("t3a_out", {8'd0, Output},   16'h00FF);
        check_val("t3a_ovf", {15'd0, ovf},     16'd0);
        run_op(lat);
        check_val("t3b_lat",  lat[15:0], 16'd3);
        check_val("t3b_id",   {15'd0, done_id}, 16'd1);
        check_val("t3b_out",  {8'd0, Output},   16'h0080);
        check_val("t3b_ovf",  {15'd0, ovf},     16'd1);
        check_val("t3b_cout", {15'd0, c_out},   16'd0);
        run_op(lat);
        check_val("t3c_id",  {15'd0, done_id}, 16'd0);
        check_val("t3c_out", {8'd0, Output},   16'h00FF);
        req = 2'b00;
        tick();

        // Reset asserted while in HIGH: abort with no done.
        req = 2'b01; A0 = 8'h05;
        tick();
        tick();
        req = 2'b00;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t4");
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) dones++;
        end
        check_val("t4_nodone", dones[15:0], 16'd0);
        rst_n = 1'b1;
        req = 2'b10; A1 = 8'h02;
        run_op(lat);
        check_val("t4_gnt_id", {15'd0, done_id}, 16'd1);
        check_val("t4_out",    {8'd0, Output},   16'h00FE);
        req = 2'b00;
        tick();

        // Enable held low for 5 cycles while in LOW.
        req = 2'b01; A0 = 8'h03;
        tick();
        en = 1'b0;
        req = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        check_val("t5_frz_busy", {15'd0, busy}, 16'd1);
        check_val("t5_frz_gnt",  {14'd0, gnt},  16'h0001);
        check_val("t5_frz_out",  {8'd0, Output}, 16'h00FE);
        en = 1'b1;
        lat = 5;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        check_val("t5_lat", lat[15:0], 16'd8);
        check_val("t5_out", {8'd0, Output}, 16'h00FD);
        tick();

        // Operand changed after the grant edge has no effect.
        req = 2'b01; A0 = 8'h10;
        tick();
        A0 = 8'h33;
        req = 2'b00;
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check_val("t6_lat", lat[15:0], 16'd3);
        check_val("t6_out", {8'd0, Output}, 16'h00F0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
